pipeline_branch_tracker: RTL and testbench

PIPELINE_BRANCH_TRACKER -- requirements
Module: pipeline_branch_tracker

---
 rtl/pipeline_branch_tracker.sv | 111 +++++++++++
 tb/tb_pipeline_branch_tracker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_branch_tracker.sv
// Branch resolution tracker: follows one control-transfer instruction from
// ID through EX resolution, drives the IF/ID flush and fetch redirect for
// taken transfers, and keeps saturating resolved/taken counters.
module pipeline_branch_tracker (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        jump_start,
    input  logic [1:0]  jump_kind,
    input  logic        pipeline_stall,
    input  logic        take_branch,
    output logic [1:0]  branch_status,
    output logic        flush_if,
    output logic        flush_id,
    output logic        pc_redirect,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
);

    // State encoding doubles as the branch_status encoding.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RESOLVE   = 2'b01,
        ST_TAKEN     = 2'b10,
        ST_NOT_TAKEN = 2'b11
    } state_t;

    localparam logic [1:0]  KIND_JAL  = 2'b01;
    localparam logic [1:0]  KIND_JALR = 2'b10;
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    logic [1:0]  kind_q, kind_d;
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] taken_count_q, taken_count_d;
    logic [1:0]  status_q;
    logic        resolve_taken;

    // Unconditional jumps always resolve taken; reserved kind 11 behaves as a
    // conditional branch because only 01/10 are matched here.
    assign resolve_taken = (kind_q == KIND_JAL) || (kind_q == KIND_JALR) || take_branch;

    // Next-state, stored-kind and counter update; a stall freezes everything.
    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;
        if (!pipeline_stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (jump_start) begin
                        kind_d  = jump_kind;
                        state_d = ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    if (branch_count_q != CNT_MAX) begin
                        branch_count_d = branch_count_q + 32'd1;
                    end
                    if (resolve_taken) begin
                        state_d = ST_TAKEN;
                        if (taken_count_q != CNT_MAX) begin
                            taken_count_d = taken_count_q + 32'd1;
                        end
                    end else begin
                        state_d = ST_NOT_TAKEN;
                    end
                end
                ST_TAKEN: begin
                    // jump_start is ignored here: the ID instruction is being flushed.
                    state_d = ST_IDLE;
                end
                ST_NOT_TAKEN: begin
                    if (jump_start) begin
                        kind_d  = jump_kind;
                        state_d = ST_RESOLVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Register state, kind, counters and the registered status decode together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            kind_q         <= 2'b00;
            branch_count_q <= 32'd0;
            taken_count_q  <= 32'd0;
            status_q       <= 2'b00;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
            status_q       <= state_d;
        end
    end

    // Flushes and redirect follow the TAKEN state directly, stalled or not.
    assign flush_if      = (state_q == ST_TAKEN);
    assign flush_id      = (state_q == ST_TAKEN);
    assign pc_redirect   = (state_q == ST_TAKEN);
    assign branch_status = status_q;
    assign branch_count  = branch_count_q;
    assign taken_count   = taken_count_q;

endmodule

// File: tb/tb_pipeline_branch_tracker.sv
// Testbench for pipeline_branch_tracker: directed scenarios with constant
// expectations plus randomized traffic checked against a behavioural model.
module tb_pipeline_branch_tracker;

    logic        clock;
    logic        reset_n;
    logic        jump_start;
    logic [1:0]  jump_kind;
    logic        pipeline_stall;
    logic        take_branch;
    logic [1:0]  branch_status;
    logic        flush_if;
    logic        flush_id;
    logic        pc_redirect;
    logic [31:0] branch_count;
    logic [31:0] taken_count;

    int errors = 0;
    int checks = 0;

    pipeline_branch_tracker dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .jump_start     (jump_start),
        .jump_kind      (jump_kind),
        .pipeline_stall (pipeline_stall),
        .take_branch    (take_branch),
        .branch_status  (branch_status),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .pc_redirect    (pc_redirect),
        .branch_count   (branch_count),
        .taken_count    (taken_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural reference: what the tracker is doing (0 idle, 1 waiting for
    // resolution, 2 taken redirect, 3 not-taken), the pending kind, and counts.
    int      m_phase;
    int      m_kind;
    longint  m_resolved;
    longint  m_taken;
    int      txn_no = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase    = 0;
        m_kind     = 0;
        m_resolved = 0;
        m_taken    = 0;
    endfunction

    // Apply one clock edge to the reference using the inputs seen at that edge.
    function automatic void model_edge(input logic js, input logic [1:0] jk,
                                       input logic st, input logic tk);
        bit is_taken;
        if (st) return;
        if (m_phase == 0) begin
            if (js) begin m_kind = int'(jk); m_phase = 1; end
        end else if (m_phase == 1) begin
            is_taken = (m_kind == 1) || (m_kind == 2) || tk;
            if (m_resolved < 64'hFFFF_FFFF) m_resolved++;
            if (is_taken && m_taken < 64'hFFFF_FFFF) m_taken++;
            m_phase = is_taken ? 2 : 3;
            txn_no++;
            $display("txn %0d: kind=%0d taken=%0d resolved=%0d taken_total=%0d",
                     txn_no, m_kind, is_taken, m_resolved, m_taken);
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else begin
            if (js) begin m_kind = int'(jk); m_phase = 1; end
            else m_phase = 0;
        end
    endfunction

    task automatic check_model(input string tag);
        logic fl;
        fl = (m_phase == 2);
        check_eq({tag, "_status"}, {30'd0, branch_status}, m_phase[31:0]);
        check_eq({tag, "_flush_if"}, {31'd0, flush_if}, {31'd0, fl});
        check_eq({tag, "_flush_id"}, {31'd0, flush_id}, {31'd0, fl});
        check_eq({tag, "_redirect"}, {31'd0, pc_redirect}, {31'd0, fl});
        check_eq({tag, "_bcnt"}, branch_count, m_resolved[31:0]);
        check_eq({tag, "_tcnt"}, taken_count, m_taken[31:0]);
    endtask

    // One cycle: drive inputs, take the edge, update the model, check #1 later.
    task automatic step(input logic js, input logic [1:0] jk, input logic st, input logic tk);
        jump_start     = js;
        jump_kind      = jk;
        pipeline_stall = st;
        take_branch    = tk;
        @(posedge clock);
        model_edge(js, jk, st, tk);
        #1;
        check_model("step");
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_status"}, {30'd0, branch_status}, 32'd0);
        check_eq({tag, "_flush"}, {29'd0, flush_if, flush_id, pc_redirect}, 32'd0);
        check_eq({tag, "_bcnt"}, branch_count, 32'd0);
        check_eq({tag, "_tcnt"}, taken_count, 32'd0);
    endtask

    // Asynchronous reset mid-cycle with random inputs; released mid-cycle.
    task automatic do_reset();
        reset_n        = 1'b0;
        jump_start     = 1'($urandom);
        jump_kind      = 2'($urandom);
        pipeline_stall = 1'($urandom);
        take_branch    = 1'($urandom);
        #1;
        check_all_zero("rst_async");
        model_reset();
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        check_all_zero("rst_release");
    endtask

    initial begin
        reset_n        = 1'b1;
        jump_start     = 1'b0;
        jump_kind      = 2'b00;
        pipeline_stall = 1'b0;
        take_branch    = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Taken conditional branch.
        $display("scenario: taken conditional branch");
        step(1'b1, 2'b00, 1'b0, 1'b0);
        check_eq("tkn_c1_status", {30'd0, branch_status}, 32'd1);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        check_eq("tkn_c2_status", {30'd0, branch_status}, 32'd2);
        check_eq("tkn_c2_flush", {29'd0, flush_if, flush_id, pc_redirect}, 32'd7);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("tkn_c3_status", {30'd0, branch_status}, 32'd0);
        check_eq("tkn_bcnt", branch_count, 32'd1);
        check_eq("tkn_tcnt", taken_count, 32'd1);

        // jal with take_branch low still resolves taken.
        $display("scenario: jal with take_branch=0");
        do_reset();
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        check_eq("jal_c2_status", {30'd0, branch_status}, 32'd2);
        check_eq("jal_tcnt", taken_count, 32'd1);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        check_eq("jal_ignore_js", {30'd0, branch_status}, 32'd0);

        // Back-to-back not-taken branches; reserved kind 11 acts as conditional.
        $display("scenario: back-to-back not-taken");
        do_reset();
        step(1'b1, 2'b00, 1'b0, 1'b0);
        check_eq("nt_c1", {30'd0, branch_status}, 32'd1);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("nt_c2", {30'd0, branch_status}, 32'd3);
        step(1'b1, 2'b11, 1'b0, 1'b0);
        check_eq("nt_c3", {30'd0, branch_status}, 32'd1);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("nt_c4", {30'd0, branch_status}, 32'd3);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("nt_c5", {30'd0, branch_status}, 32'd0);
        check_eq("nt_bcnt", branch_count, 32'd2);
        check_eq("nt_tcnt", taken_count, 32'd0);

        // Stalls in RESOLVE and TAKEN.
        $display("scenario: stalls in RESOLVE and TAKEN");
        do_reset();
        step(1'b1, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b01, 1'b1, 1'b1);
            check_eq("stl_res_status", {30'd0, branch_status}, 32'd1);
            check_eq("stl_res_bcnt", branch_count, 32'd0);
        end
        step(1'b0, 2'b00, 1'b0, 1'b1);
        check_eq("stl_tkn_status", {30'd0, branch_status}, 32'd2);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 2'b00, 1'b1, 1'b0);
            check_eq("stl_tkn_status", {30'd0, branch_status}, 32'd2);
            check_eq("stl_tkn_flush", {29'd0, flush_if, flush_id, pc_redirect}, 32'd7);
        end
        step(1'b0, 2'b00, 1'b0, 1'b0);
        check_eq("stl_end_status", {30'd0, branch_status}, 32'd0);
        check_eq("stl_bcnt", branch_count, 32'd1);
        check_eq("stl_tcnt", taken_count, 32'd1);

        // Saturation: preload counters near the top, resolve three jal jumps.
        $display("scenario: counter saturation and mid-resolve reset");
        do_reset();
        @(negedge clock);
        force dut.branch_count_q = 32'hFFFF_FFFE;
        force dut.taken_count_q  = 32'hFFFF_FFFE;
        @(posedge clock);
        #1;
        release dut.branch_count_q;
        release dut.taken_count_q;
        m_resolved = 64'hFFFF_FFFE;
        m_taken    = 64'hFFFF_FFFE;
        check_model("preload");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b01, 1'b0, 1'b0);
            step(1'b0, 2'b00, 1'b0, 1'b0);
            step(1'b0, 2'b00, 1'b0, 1'b0);
        end
        check_eq("sat_bcnt", branch_count, 32'hFFFF_FFFF);
        check_eq("sat_tcnt", taken_count, 32'hFFFF_FFFF);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        check_eq("midrst_pre", {30'd0, branch_status}, 32'd1);
        do_reset();
        step(1'b0, 2'b00, 1'b0, 1'b1);
        check_eq("midrst_status", {30'd0, branch_status}, 32'd0);
        check_eq("midrst_bcnt", branch_count, 32'd0);

        // Randomized traffic against the reference model.
        $display("scenario: randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 2'($urandom),
                     ($urandom_range(0, 3) == 0), 1'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
